// File: rtl/mrv1_ibuffer.sv
// Per-thread instruction buffer between fetch and decode with round-robin issue arbitration.
// Optional macro MRV1_IBUF_STALL_CNT_EN adds a saturating decode-stall cycle counter (stall_cnt_o).
module mrv1_ibuffer #(
    parameter int unsigned PC_WIDTH_P    = 32,
    parameter int unsigned NUM_THREADS_P = 8,
    parameter int unsigned DEPTH_P       = 4,
    localparam int unsigned TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fetch_vld_i,
    input  logic [TID_WIDTH_LP-1:0]  fetch_tid_i,
    input  logic [31:0]              fetch_insn_i,
    input  logic [PC_WIDTH_P-1:0]    fetch_pc_i,
    output logic [NUM_THREADS_P-1:0] fetch_rdy_o,
    input  logic [NUM_THREADS_P-1:0] flush_i,
    input  logic [NUM_THREADS_P-1:0] thread_en_i,
    output logic                     insn_vld_o,
    output logic [31:0]              insn_o,
    output logic [PC_WIDTH_P-1:0]    insn_pc_o,
    output logic [TID_WIDTH_LP-1:0]  insn_tid_o,
    input  logic                     dec_rdy_i,
`ifdef MRV1_IBUF_STALL_CNT_EN
    output logic [31:0]              stall_cnt_o,
`endif
    output logic [NUM_THREADS_P-1:0] empty_o
);

    localparam int unsigned PTR_W_LP = $clog2(DEPTH_P);
    localparam int unsigned CNT_W_LP = PTR_W_LP + 1;
    localparam logic [CNT_W_LP-1:0] FULL_CNT_LP = CNT_W_LP'(DEPTH_P);

    logic [31:0]           insn_mem_q [NUM_THREADS_P][DEPTH_P];
    logic [PC_WIDTH_P-1:0] pc_mem_q   [NUM_THREADS_P][DEPTH_P];

    logic [NUM_THREADS_P-1:0][PTR_W_LP-1:0] rptr_q, rptr_d;
    logic [NUM_THREADS_P-1:0][PTR_W_LP-1:0] wptr_q, wptr_d;
    logic [NUM_THREADS_P-1:0][CNT_W_LP-1:0] cnt_q, cnt_d;

    logic [TID_WIDTH_LP-1:0] last_grant_q, last_grant_d;
    logic                    lock_q, lock_d;
    logic [TID_WIDTH_LP-1:0] lock_tid_q, lock_tid_d;

    logic [NUM_THREADS_P-1:0] elig;
    logic [NUM_THREADS_P-1:0] push_vec;
    logic [NUM_THREADS_P-1:0] pop_vec;
    logic                     grant_vld;
    logic [TID_WIDTH_LP-1:0]  grant_tid;
    logic [TID_WIDTH_LP-1:0]  cand;
    logic                     push;
    logic                     pop;

    always_comb begin
        for (int t = 0; t < NUM_THREADS_P; t++) begin
            fetch_rdy_o[t] = (cnt_q[t] != FULL_CNT_LP);
            empty_o[t]     = (cnt_q[t] == '0);
            elig[t]        = thread_en_i[t] && (cnt_q[t] != '0) && !flush_i[t];
        end
    end

    // Downward scan so the closest thread after last_grant wins; offset N maps to last_grant itself.
    always_comb begin
        grant_vld = 1'b0;
        grant_tid = '0;
        cand      = '0;
        if (lock_q) begin
            grant_tid = lock_tid_q;
            grant_vld = (cnt_q[lock_tid_q] != '0) && !flush_i[lock_tid_q];
        end else begin
            for (int i = NUM_THREADS_P; i >= 1; i--) begin
                cand = last_grant_q + TID_WIDTH_LP'(i);
                if (elig[cand]) begin
                    grant_vld = 1'b1;
                    grant_tid = cand;
                end
            end
        end
    end

    always_comb begin
        insn_vld_o = grant_vld;
        insn_o     = '0;
        insn_pc_o  = '0;
        insn_tid_o = '0;
        if (grant_vld) begin
            insn_o     = insn_mem_q[grant_tid][rptr_q[grant_tid]];
            insn_pc_o  = pc_mem_q[grant_tid][rptr_q[grant_tid]];
            insn_tid_o = grant_tid;
        end
    end

    assign push = fetch_vld_i && fetch_rdy_o[fetch_tid_i] && !flush_i[fetch_tid_i];
    assign pop  = grant_vld && dec_rdy_i;

    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        if (push) begin
            push_vec[fetch_tid_i] = 1'b1;
        end
        if (pop) begin
            pop_vec[grant_tid] = 1'b1;
        end
    end

    // A flushed thread is never granted, so flush and pop never coincide on one thread.
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        for (int t = 0; t < NUM_THREADS_P; t++) begin
            if (flush_i[t]) begin
                rptr_d[t] = '0;
                wptr_d[t] = '0;
                cnt_d[t]  = '0;
            end else begin
                if (push_vec[t]) begin
                    wptr_d[t] = wptr_q[t] + PTR_W_LP'(1);
                end
                if (pop_vec[t]) begin
                    rptr_d[t] = rptr_q[t] + PTR_W_LP'(1);
                end
                cnt_d[t] = cnt_q[t] + CNT_W_LP'(push_vec[t]) - CNT_W_LP'(pop_vec[t]);
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        lock_tid_d   = lock_tid_q;
        lock_d       = grant_vld && !dec_rdy_i;
        if (pop) begin
            last_grant_d = grant_tid;
        end
        if (grant_vld) begin
            lock_tid_d = grant_tid;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            cnt_q        <= '0;
            last_grant_q <= TID_WIDTH_LP'(NUM_THREADS_P - 1);
            lock_q       <= 1'b0;
            lock_tid_q   <= '0;
        end else begin
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_tid_q   <= lock_tid_d;
        end
    end

    // Storage needs no reset: data outputs are masked while nothing is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            insn_mem_q[fetch_tid_i][wptr_q[fetch_tid_i]] <= fetch_insn_i;
            pc_mem_q[fetch_tid_i][wptr_q[fetch_tid_i]]   <= fetch_pc_i;
        end
    end

`ifdef MRV1_IBUF_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (grant_vld && !dec_rdy_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mrv1_ibuffer.sv
// Directed self-checking bench for mrv1_ibuffer (default parameters).
// Define MRV1_IBUF_STALL_CNT_EN to also check the stall counter.
module tb_mrv1_ibuffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_vld_i;
    logic [2:0]  fetch_tid_i;
    logic [31:0] fetch_insn_i;
    logic [31:0] fetch_pc_i;
    logic [7:0]  fetch_rdy_o;
    logic [7:0]  flush_i;
    logic [7:0]  thread_en_i;
    logic        insn_vld_o;
    logic [31:0] insn_o;
    logic [31:0] insn_pc_o;
    logic [2:0]  insn_tid_o;
    logic        dec_rdy_i;
    logic [7:0]  empty_o;
`ifdef MRV1_IBUF_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    mrv1_ibuffer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fetch_vld_i (fetch_vld_i),
        .fetch_tid_i (fetch_tid_i),
        .fetch_insn_i(fetch_insn_i),
        .fetch_pc_i  (fetch_pc_i),
        .fetch_rdy_o (fetch_rdy_o),
        .flush_i     (flush_i),
        .thread_en_i (thread_en_i),
        .insn_vld_o  (insn_vld_o),
        .insn_o      (insn_o),
        .insn_pc_o   (insn_pc_o),
        .insn_tid_o  (insn_tid_o),
        .dec_rdy_i   (dec_rdy_i),
`ifdef MRV1_IBUF_STALL_CNT_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [2:0] tid, input logic [31:0] insn, input logic [31:0] pc);
        fetch_vld_i  = 1'b1;
        fetch_tid_i  = tid;
        fetch_insn_i = insn;
        fetch_pc_i   = pc;
    endtask

    task automatic idle_fetch();
        fetch_vld_i  = 1'b0;
        fetch_tid_i  = '0;
        fetch_insn_i = '0;
        fetch_pc_i   = '0;
    endtask

    logic [2:0] order [6];

    initial begin
        order = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
        rst_i       = 1'b1;
        flush_i     = '0;
        thread_en_i = 8'hFF;
        dec_rdy_i   = 1'b1;
        idle_fetch();
        #1;
        chk("rst_fetch_rdy", 64'(fetch_rdy_o), 64'hFF);
        chk("rst_empty", 64'(empty_o), 64'hFF);
        chk("rst_vld", 64'(insn_vld_o), 64'd0);
        chk("rst_insn", 64'(insn_o), 64'd0);
        chk("rst_pc", 64'(insn_pc_o), 64'd0);
        chk("rst_tid", 64'(insn_tid_o), 64'd0);
        tick();
        tick();
        rst_i = 1'b0;

        // Single push to thread 2: no bypass, visible next cycle, then popped.
        push(3'd2, 32'h0000_0013, 32'h100);
        #1;
        chk("t1_no_bypass", 64'(insn_vld_o), 64'd0);
        tick();
        idle_fetch();
        #1;
        chk("t1_vld", 64'(insn_vld_o), 64'd1);
        chk("t1_insn", 64'(insn_o), 64'h13);
        chk("t1_pc", 64'(insn_pc_o), 64'h100);
        chk("t1_tid", 64'(insn_tid_o), 64'd2);
        tick();
        chk("t1_empty2", 64'(empty_o[2]), 64'd1);
        chk("t1_vld_after", 64'(insn_vld_o), 64'd0);

        // Fill thread 0 while decode stalls; fifth push dropped.
        dec_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(3'd0, 32'hA0 + 32'(i), 32'h200 + 32'(4 * i));
            #1;
            if (i > 0) chk("t2_hold_head", 64'(insn_o), 64'hA0);
            tick();
        end
        chk("t2_full_rdy", 64'(fetch_rdy_o[0]), 64'd0);
        push(3'd0, 32'hBAD, 32'h2F0);
        tick();
        chk("t2_still_full", 64'(fetch_rdy_o[0]), 64'd0);
        idle_fetch();
        dec_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_drain_vld", 64'(insn_vld_o), 64'd1);
            chk("t2_drain_insn", 64'(insn_o), 64'hA0 + 64'(i));
            chk("t2_drain_pc", 64'(insn_pc_o), 64'h200 + 64'(4 * i));
            tick();
        end
        chk("t2_drained_vld", 64'(insn_vld_o), 64'd0);
        chk("t2_drained_empty", 64'(empty_o[0]), 64'd1);

        // Reset mid-operation discards a buffered entry and restores the arbiter pointer.
        thread_en_i = '0;
        push(3'd4, 32'h44, 32'h440);
        tick();
        idle_fetch();
        #1;
        chk("rst2_pre_empty4", 64'(empty_o[4]), 64'd0);
        rst_i = 1'b1;
        #1;
        chk("rst2_empty", 64'(empty_o), 64'hFF);
        chk("rst2_rdy", 64'(fetch_rdy_o), 64'hFF);
        tick();
        rst_i = 1'b0;

        // Round-robin over threads 0, 1, 3 with two entries each.
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                push(order[j], 32'h300 + 32'(order[j]) * 16 + 32'(k), 32'h3000 + 32'(4 * k));
                tick();
            end
        end
        idle_fetch();
        thread_en_i = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t3_rr_tid", 64'(insn_tid_o), 64'(order[i]));
            chk("t3_rr_insn", 64'(insn_o), 64'h300 + 64'(order[i]) * 16 + 64'(i / 3));
            tick();
        end
        chk("t3_done_vld", 64'(insn_vld_o), 64'd0);

        // Stall hold: thread 1 stays presented even after it is disabled.
        thread_en_i = '0;
        push(3'd1, 32'h41, 32'h410);
        tick();
        push(3'd0, 32'h40, 32'h400);
        tick();
        idle_fetch();
        dec_rdy_i   = 1'b0;
        thread_en_i = 8'h02;
        #1;
        chk("t4_first_tid", 64'(insn_tid_o), 64'd1);
        tick();
        thread_en_i = 8'h01;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4_hold_tid", 64'(insn_tid_o), 64'd1);
            chk("t4_hold_pc", 64'(insn_pc_o), 64'h410);
            tick();
        end
        dec_rdy_i = 1'b1;
        #1;
        chk("t4_pop_tid", 64'(insn_tid_o), 64'd1);
        tick();
        chk("t4_next_tid", 64'(insn_tid_o), 64'd0);
        chk("t4_next_pc", 64'(insn_pc_o), 64'h400);
        tick();
        chk("t4_done_vld", 64'(insn_vld_o), 64'd0);

        // Flush of the stalled presented thread with a same-cycle push to it.
        thread_en_i = 8'hFF;
        push(3'd1, 32'h51, 32'h510);
        tick();
        idle_fetch();
        dec_rdy_i = 1'b0;
        #1;
        chk("t5_presented", 64'(insn_tid_o), 64'd1);
        tick();
        flush_i = 8'h02;
        push(3'd1, 32'h52, 32'h520);
        #1;
        chk("t5_flush_vld", 64'(insn_vld_o), 64'd0);
        chk("t5_flush_insn", 64'(insn_o), 64'd0);
        tick();
        flush_i = '0;
        idle_fetch();
        dec_rdy_i = 1'b1;
        #1;
        chk("t5_empty1", 64'(empty_o[1]), 64'd1);
        chk("t5_rdy1", 64'(fetch_rdy_o[1]), 64'd1);
        chk("t5_absent", 64'(insn_vld_o), 64'd0);

        // Five stalled valid cycles on a freshly reset buffer.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        push(3'd5, 32'h77, 32'h770);
        dec_rdy_i = 1'b0;
        tick();
        idle_fetch();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t6_stall_tid", 64'(insn_tid_o), 64'd5);
            chk("t6_stall_vld", 64'(insn_vld_o), 64'd1);
            tick();
        end
`ifdef MRV1_IBUF_STALL_CNT_EN
        chk("t6_stall_cnt", 64'(stall_cnt_o), 64'd5);
`endif
        dec_rdy_i = 1'b1;
        tick();
        chk("t6_final_empty", 64'(empty_o), 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mrv1_ibuffer.md
Name: mrv1_ibuffer

Overview:
- Per-thread instruction buffer between the multithreaded fetch unit and the instruction decode stage.
- Holds up to DEPTH_P fetched 32-bit instruction words (raw; RVC expansion happens in decode) per hardware thread.
- Each cycle a round-robin arbiter over eligible, non-empty threads presents one instruction with its PC and thread id to decode through a valid/ready handshake.
- Per-thread flush supports redirects (branch/jump resolution, traps).

Parameters:
- PC_WIDTH_P, 32, width of instruction PC.
- NUM_THREADS_P, 8, number of hardware threads; power of 2, at least 2.
- DEPTH_P, 4, entries per thread FIFO; power of 2, at least 2.
- TID_WIDTH_LP, $clog2(NUM_THREADS_P), thread id width (local).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- fetch_vld_i  in  1  fetch presents an instruction.
- fetch_tid_i  in  TID_WIDTH_LP  thread of fetched instruction.
- fetch_insn_i  in  32  raw instruction word.
- fetch_pc_i  in  PC_WIDTH_P  instruction PC.
- fetch_rdy_o  out  NUM_THREADS_P  per-thread: FIFO not full.
- flush_i  in  NUM_THREADS_P  per-thread flush.
- thread_en_i  in  NUM_THREADS_P  per-thread issue eligibility (not stalled by scheduler/hazard).
- insn_vld_o  out  1  instruction valid to decode.
- insn_o  out  32  instruction word.
- insn_pc_o  out  PC_WIDTH_P  instruction PC.
- insn_tid_o  out  TID_WIDTH_LP  instruction thread id.
- dec_rdy_i  in  1  decode accepts.
- empty_o  out  NUM_THREADS_P  per-thread FIFO empty.

Behaviour:
- Reset: all counts, read/write pointers zero; round-robin last-grant = NUM_THREADS_P-1 (thread 0 highest priority first); lock flag 0. Outputs: fetch_rdy_o all 1, empty_o all 1, insn_vld_o 0, insn_o/insn_pc_o/insn_tid_o 0. Reset mid-operation discards all entries immediately.
- Storage per thread: circular FIFO, $clog2(DEPTH_P)-bit pointers wrap naturally; count is $clog2(DEPTH_P)+1 bits.
- fetch_rdy_o[t] = (count[t] != DEPTH_P). Registered-count based only; a pop in the same cycle does not make a full thread ready.
- Push: fetch_vld_i && fetch_rdy_o[fetch_tid_i] && !flush_i[fetch_tid_i]. Write at wptr, wptr+1, count+1. Push to a full thread is dropped, with no state change.
- Latency: a pushed entry is visible to decode the next cycle at the earliest. There is no fetch-to-decode bypass.
- Eligible[t] = thread_en_i[t] && count[t]!=0 && !flush_i[t].
- Arbitration: when unlocked, grant the first eligible thread searching from last-grant+1, wrapping modulo NUM_THREADS_P.
- insn_vld_o = grant valid. insn_o/insn_pc_o/insn_tid_o come combinationally from the granted FIFO head. When insn_vld_o is 0, data outputs are 0.
- Handshake: pop when insn_vld_o && dec_rdy_i. rptr+1, count-1, last-grant <= granted tid, lock cleared.
- Stall hold: if insn_vld_o && !dec_rdy_i, lock set and locked tid stored. While locked, the same thread and entry stay presented, ignoring thread_en_i and other threads.
- Flush: flush_i[t] clears count/pointers of t at the clock edge. Same-cycle push to t is dropped. A combinational flush of the presented or locked thread deasserts insn_vld_o that same cycle, no pop occurs, and the lock is cleared. This is the only case where a valid is withdrawn without a handshake.
- Simultaneous push and pop on the same thread: count unchanged, both pointers advance.
- empty_o[t] = (count[t]==0), registered-count based.

Optional Feature:
- Macro MRV1_IBUF_STALL_CNT_EN.
- When defined: adds output port stall_cnt_o (out, 32) and a 32-bit counter. The counter increments every cycle with insn_vld_o && !dec_rdy_i, saturates at 32'hFFFF_FFFF, and resets to 0 on rst_i.
- When undefined: neither the port nor the counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then push thread 2 insn 0x00000013 PC 0x100 with dec_rdy_i=1 -> next cycle insn_vld_o=1, insn_o=0x13, insn_pc_o=0x100, insn_tid_o=2; cycle after that empty_o[2]=1.
- Push 4 entries to thread 0 with DEPTH_P=4 and dec_rdy_i=0 -> fetch_rdy_o[0]=0; a 5th push is dropped; draining yields exactly the 4 entries in order.
- Threads 0, 1 and 3 each hold 2 entries, all enabled, dec_rdy_i=1 -> issue order tid 0,1,3,0,1,3.
- Thread 1 presented with dec_rdy_i=0 for 3 cycles, thread_en_i[1] dropped and thread 0 made eligible -> output stays tid 1 with the same PC; pops on the dec_rdy_i rise; then thread 0 issues.
- Thread 1 presented and stalled, flush_i[1] pulsed with a same-cycle push to thread 1 -> insn_vld_o=0 that cycle; next cycle count[1]=0, empty_o[1]=1, and the pushed entry is absent.
- With MRV1_IBUF_STALL_CNT_EN defined, hold dec_rdy_i=0 for 5 valid cycles -> stall_cnt_o=5.
